line_pixel_writer: RTL

- Consumes the (x, y) pixel stream produced by the line drawer and commits each pixel to the framebuffer memory.
- Clips off-screen pixels and linearises coordinates to addresses (addr = y*SCREEN_W + x).
- Buffers pixels in a small FIFO so the drawer is decoupled from memory write latency.
- Reports write/clip counts and a one-cycle frame_done pulse once a finished line has fully drained.

---
 rtl/line_pixel_writer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/line_pixel_writer.sv
// rtl/line_pixel_writer.sv - clips, linearises and queues drawer pixels, then commits them to the framebuffer
module line_pixel_writer #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned COLOR_W    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [10:0]        pix_x,
  input  logic [10:0]        pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  output logic               pix_ready,
  input  logic               line_done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_we,
  input  logic               mem_ack,
  output logic [15:0]        pixel_count,
  output logic [15:0]        clip_count,
  output logic               frame_done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  fifo_addr  [FIFO_DEPTH];
  logic [COLOR_W-1:0] fifo_color [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               line_done_q;
  logic               done_pending;

  logic               fifo_empty;
  logic               fifo_full;
  logic               in_bounds;
  logic               take;
  logic               push;
  logic               clip;
  logic               pop;
  logic [ADDR_W-1:0]  lin_addr;

  // Handshake, clipping and address linearisation; ready only looks at registered occupancy
  always_comb begin
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    in_bounds  = (32'(pix_x) < SCREEN_W) && (32'(pix_y) < SCREEN_H);
    lin_addr   = ADDR_W'(pix_y) * ADDR_W'(SCREEN_W) + ADDR_W'(pix_x);
    take       = pix_valid && !fifo_full;
    push       = take && in_bounds;
    clip       = take && !in_bounds;
    pop        = !fifo_empty && ((state == S_IDLE) || mem_ack);
  end

  assign pix_ready = !fifo_full;

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless once the pointers are cleared
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= lin_addr;
      fifo_color[wr_ptr] <= pix_color;
    end
  end

  // Write FSM: holds the request until acked, chains back-to-back pops while data is queued
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      pixel_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            mem_addr <= fifo_addr[rd_ptr];
            mem_data <= fifo_color[rd_ptr];
            mem_we   <= 1'b1;
            state    <= S_WRITE;
          end else begin
            mem_we <= 1'b0;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            pixel_count <= pixel_count + 16'd1;
            if (!fifo_empty) begin
              mem_addr <= fifo_addr[rd_ptr];
              mem_data <= fifo_color[rd_ptr];
            end else begin
              mem_we <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        default: begin
          mem_we <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Clip counter
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_count <= '0;
    end else if (clip) begin
      clip_count <= clip_count + 16'd1;
    end
  end

  // Line completion: latch the rising edge, pulse once the pipeline has fully drained
  always_ff @(posedge clk) begin
    if (reset) begin
      line_done_q  <= 1'b1;
      done_pending <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      line_done_q <= line_done;
      frame_done  <= 1'b0;
      if (done_pending && (state == S_IDLE) && fifo_empty) begin
        frame_done   <= 1'b1;
        done_pending <= 1'b0;
      end else if (line_done && !line_done_q) begin
        done_pending <= 1'b1;
      end
    end
  end

endmodule
